pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter OFF_W, default 8, branch-offset width in bits (OFF_W <= PC_W).
REQ-003 SHALL have parameter DEPTH, default 4, return-stack entries (power of two, >= 2).
REQ-004 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port EN  input  1  advance enable; 0 = stall.
REQ-008 SHALL have port BRANCH  input  1  take relative branch.
REQ-009 SHALL have port OFFSET  input  OFF_W  signed two's-complement branch offset.
REQ-010 SHALL have port JUMP  input  1  absolute jump to TARGET.
REQ-011 SHALL have port CALL  input  1  push return address, jump to TARGET.
REQ-012 SHALL have port RET  input  1  pop return address into PC.
REQ-013 SHALL have port TARGET  input  PC_W  absolute destination for JUMP/CALL.
REQ-014 SHALL have port PC  output  PC_W  current program counter (registered).
REQ-015 SHALL have port NEXT_PC  output  PC_W  combinational value PC takes at next edge.
REQ-016 SHALL have port STACK_FULL  output  1  stack holds DEPTH entries.
REQ-017 SHALL have port STACK_EMPTY  output  1  stack holds 0 entries.
REQ-018 SHALL have port ERR  output  1  one-cycle pulse on overflow/underflow.

Function
REQ-019 SHALL, with EN=1, select NEXT_PC by fixed priority JUMP > CALL > RET > BRANCH > sequential; lower-priority requests that cycle are ignored, no state change.
REQ-020 SHALL compute sequential NEXT_PC = PC + 1, modulo 2^PC_W (0xFFFF wraps to 0x0000).
REQ-021 SHALL compute BRANCH NEXT_PC = PC + sign-extend(OFFSET), modulo 2^PC_W; negative offsets move backward.
REQ-022 SHALL, on JUMP, set NEXT_PC = TARGET with stack unchanged.
REQ-023 SHALL, on CALL with stack not full, push PC+1 (mod 2^PC_W), increment count, set NEXT_PC = TARGET.
REQ-024 SHALL, on CALL with stack full, set NEXT_PC = TARGET, discard push, keep stack contents and count, pulse ERR.
REQ-025 SHALL, on RET with stack not empty, set NEXT_PC = top entry, decrement count.
REQ-026 SHALL, on RET with stack empty, take sequential NEXT_PC = PC+1 and pulse ERR.
REQ-027 SHALL, with EN=0, hold PC, stack and count, force NEXT_PC = PC and ERR = 0, and ignore all requests.
REQ-028 SHALL register ERR: high for exactly the cycle after the offending edge, then 0 unless re-triggered.
REQ-029 SHALL derive STACK_FULL (count == DEPTH) and STACK_EMPTY (count == 0) from the registered count, updated one edge after the push/pop.
REQ-030 SHALL implement the stack as LIFO: last pushed address returned first.

Reset
REQ-031 SHALL, on a rising CLK edge with RESET_N=0, set PC = RESET_ADDR, count = 0, ERR = 0, overriding EN and all requests.
REQ-032 SHALL give outputs after reset: PC = RESET_ADDR, STACK_EMPTY = 1, STACK_FULL = 0, ERR = 0; stored entries need not be cleared.
REQ-033 SHALL, on reset mid-call-sequence, abandon all stacked addresses; a following RET underflows.

Verification
REQ-034 SHALL cover: reset, then EN=1 for 3 cycles -> PC 0,1,2,3; PC=0xFFFF, EN=1 -> PC=0x0000.
REQ-035 SHALL cover: PC=0x0100, BRANCH=1, OFFSET=0xEE -> PC=0x00EE; OFFSET=0x12 from 0x0100 -> PC=0x0112.
REQ-036 SHALL cover: PC=0x0010, CALL TARGET=0x0400 -> PC=0x0400, STACK_EMPTY=0; then RET -> PC=0x0011.
REQ-037 SHALL cover: 4 CALLs from PC 0x10, 0x20, 0x30, 0x40 (TARGETs 0x20, 0x30, 0x40, 0x50) -> STACK_FULL=1; 5th CALL (TARGET=0x60) -> PC=0x60, ERR=1 one cycle; 4 RETs -> PC 0x41, 0x31, 0x21, 0x11.
REQ-038 SHALL cover: RET with stack empty at PC=0x0005 -> PC=0x0006, ERR=1 one cycle; JUMP+CALL+BRANCH same cycle -> PC=TARGET, stack unchanged.
REQ-039 SHALL cover: EN=0 with BRANCH=1 for 2 cycles -> PC unchanged; RESET_N=0 with 2 entries stacked -> PC=RESET_ADDR, STACK_EMPTY=1.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with relative branch, absolute jump and a small
// call/return stack.
//
// Parameters
//   PC_W       program-counter width
//   OFF_W      signed branch-offset width (OFF_W <= PC_W)
//   DEPTH      return-stack entries (power of two, >= 2)
//   RESET_ADDR PC value after reset
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RESET_N      synchronous active-low reset
//   EN           advance enable (0 = stall, requests ignored)
//   BRANCH       PC <= PC + sext(OFFSET)
//   OFFSET       signed branch offset
//   JUMP         PC <= TARGET
//   CALL         push PC+1, PC <= TARGET
//   RET          pop top of stack into PC
//   TARGET       absolute destination for JUMP/CALL
//   PC           registered program counter
//   NEXT_PC      value PC takes at the next edge (combinational)
//   STACK_FULL   stack holds DEPTH entries
//   STACK_EMPTY  stack holds no entries
//   ERR          one-cycle pulse after a stack overflow/underflow
module pc_unit #(
    parameter int              PC_W       = 16,
    parameter int              OFF_W      = 8,
    parameter int              DEPTH      = 4,
    parameter logic [PC_W-1:0] RESET_ADDR = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             BRANCH,
    input  logic [OFF_W-1:0] OFFSET,
    input  logic             JUMP,
    input  logic             CALL,
    input  logic             RET,
    input  logic [PC_W-1:0]  TARGET,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  NEXT_PC,
    output logic             STACK_FULL,
    output logic             STACK_EMPTY,
    output logic             ERR
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            push;
    logic [PC_W-1:0] stk_q [DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;
    logic            full;
    logic            empty;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pc_inc  = pc_q + PC_W'(1);
    // Size cast of a signed operand sign-extends; also valid when OFF_W == PC_W.
    assign off_ext = PC_W'($signed(OFFSET));
    // Push slot is the low bits of the count; the top entry sits one below.
    // With a full stack the low bits wrap to 0, so top_idx wraps to DEPTH-1.
    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (EN) begin
            if (JUMP) begin
                pc_d = TARGET;
            end else if (CALL) begin
                pc_d = TARGET;
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + (AW+1)'(1);
                end
            end else if (RET) begin
                if (empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d  = stk_q[top_idx];
                    cnt_d = cnt_q - (AW+1)'(1);
                end
            end else if (BRANCH) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q  <= RESET_ADDR;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entries are not cleared by reset; the zeroed count makes them unreachable.
    always_ff @(posedge CLK) begin
        if (RESET_N && push) begin
            stk_q[wr_idx] <= pc_inc;
        end
    end

    assign PC          = pc_q;
    assign NEXT_PC     = RESET_N ? pc_d : RESET_ADDR;
    assign STACK_FULL  = full;
    assign STACK_EMPTY = empty;
    assign ERR         = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int PC_W  = 16;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;
    localparam logic [PC_W-1:0] RST_A = 16'h0000;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             EN = 1'b0;
    logic             BRANCH = 1'b0;
    logic [OFF_W-1:0] OFFSET = '0;
    logic             JUMP = 1'b0;
    logic             CALL = 1'b0;
    logic             RET = 1'b0;
    logic [PC_W-1:0]  TARGET = '0;
    logic [PC_W-1:0]  PC;
    logic [PC_W-1:0]  NEXT_PC;
    logic             STACK_FULL;
    logic             STACK_EMPTY;
    logic             ERR;

    int total = 0;
    int bad   = 0;

    pc_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .BRANCH(BRANCH), .OFFSET(OFFSET),
        .JUMP(JUMP), .CALL(CALL), .RET(RET), .TARGET(TARGET), .PC(PC),
        .NEXT_PC(NEXT_PC), .STACK_FULL(STACK_FULL), .STACK_EMPTY(STACK_EMPTY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_stk[$];
    logic            m_err;
    bit              m_valid = 0;

    // What the PC must become at the next edge, from the rules alone.
    function automatic logic [PC_W-1:0] m_next();
        int signed off;
        off = int'($signed(OFFSET));
        if (!RESET_N)          return RST_A;
        if (!EN)               return m_pc;
        if (JUMP || CALL)      return TARGET;
        if (RET)               return (m_stk.size() == 0) ? PC_W'(m_pc + 1) : m_stk[$];
        if (BRANCH)            return PC_W'(int'(m_pc) + off);
        return PC_W'(m_pc + 1);
    endfunction

    always @(posedge CLK) begin
        logic [PC_W-1:0] nx;
        nx = m_next();
        if (!RESET_N) begin
            m_stk.delete();
            m_err   = 1'b0;
            m_valid = 1;
        end else if (EN) begin
            m_err = 1'b0;
            if (!JUMP && CALL) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else m_stk.push_back(PC_W'(m_pc + 1));
            end else if (!JUMP && RET) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else void'(m_stk.pop_back());
            end
        end else begin
            m_err = 1'b0;
        end
        m_pc = nx;
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cyc_pc",    32'(PC),          32'(m_pc));
            chk("cyc_next",  32'(NEXT_PC),     32'(m_next()));
            chk("cyc_full",  32'(STACK_FULL),  32'(m_stk.size() == DEPTH));
            chk("cyc_empty", 32'(STACK_EMPTY), 32'(m_stk.size() == 0));
            chk("cyc_err",   32'(ERR),         32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Applies inputs for one cycle and returns just after the edge that used them.
    task automatic step(input logic rn, input logic en, input logic j, input logic c,
                        input logic r, input logic b, input logic [OFF_W-1:0] off,
                        input logic [PC_W-1:0] tgt);
        RESET_N = rn; EN = en; JUMP = j; CALL = c; RET = r; BRANCH = b;
        OFFSET = off; TARGET = tgt;
        @(posedge CLK);
        #1;
    endtask

    task automatic seq();                      step(1, 1, 0, 0, 0, 0, 8'h00, 16'h0); endtask
    task automatic jmp(input logic [15:0] t);  step(1, 1, 1, 0, 0, 0, 8'h00, t);     endtask
    task automatic cal(input logic [15:0] t);  step(1, 1, 0, 1, 0, 0, 8'h00, t);     endtask
    task automatic ret();                      step(1, 1, 0, 0, 1, 0, 8'h00, 16'h0); endtask
    task automatic brn(input logic [7:0] o);   step(1, 1, 0, 0, 0, 1, o, 16'h0);     endtask

    initial begin
        @(posedge CLK); #1;
        step(0, 1, 1, 1, 1, 1, 8'h7F, 16'h1234);   // reset overrides requests
        chk("rst_pc",    32'(PC), 32'h0000);
        chk("rst_empty", 32'(STACK_EMPTY), 32'd1);
        chk("rst_full",  32'(STACK_FULL), 32'd0);
        chk("rst_err",   32'(ERR), 32'd0);

        seq(); chk("seq1", 32'(PC), 32'h0001);
        seq(); chk("seq2", 32'(PC), 32'h0002);
        seq(); chk("seq3", 32'(PC), 32'h0003);

        jmp(16'hFFFF); chk("jmp_ffff", 32'(PC), 32'hFFFF);
        seq();         chk("wrap",     32'(PC), 32'h0000);

        jmp(16'h0100); brn(8'hEE); chk("br_neg", 32'(PC), 32'h00EE);
        jmp(16'h0100); brn(8'h12); chk("br_pos", 32'(PC), 32'h0112);

        jmp(16'h0010); cal(16'h0400);
        chk("call_pc",    32'(PC), 32'h0400);
        chk("call_empty", 32'(STACK_EMPTY), 32'd0);
        ret(); chk("ret_pc", 32'(PC), 32'h0011);

        jmp(16'h0010);
        cal(16'h0020); cal(16'h0030); cal(16'h0040); cal(16'h0050);
        chk("full4", 32'(STACK_FULL), 32'd1);
        cal(16'h0060);
        chk("ovf_pc",  32'(PC), 32'h0060);
        chk("ovf_err", 32'(ERR), 32'd1);
        ret(); chk("ret1", 32'(PC), 32'h0041); chk("ovf_err_clr", 32'(ERR), 32'd0);
        ret(); chk("ret2", 32'(PC), 32'h0031);
        ret(); chk("ret3", 32'(PC), 32'h0021);
        ret(); chk("ret4", 32'(PC), 32'h0011);
        chk("empty_after", 32'(STACK_EMPTY), 32'd1);

        jmp(16'h0005); ret();
        chk("unf_pc",  32'(PC), 32'h0006);
        chk("unf_err", 32'(ERR), 32'd1);
        seq(); chk("unf_err_clr", 32'(ERR), 32'd0);

        step(1, 1, 1, 1, 0, 1, 8'h05, 16'h0777);
        chk("prio_pc",    32'(PC), 32'h0777);
        chk("prio_empty", 32'(STACK_EMPTY), 32'd1);

        cal(16'h0100); cal(16'h0200);
        step(0 == 1, 1, 0, 0, 0, 0, 8'h00, 16'h0) ; // reset pulse drops both entries
        // re-stack two entries after the pulse above
        cal(16'h0100); cal(16'h0200);
        step(1, 0, 0, 0, 0, 1, 8'h10, 16'h0);
        chk("stall1_pc", 32'(PC), 32'h0200);
        chk("stall_next", 32'(NEXT_PC), 32'h0200);
        step(1, 0, 0, 0, 1, 1, 8'h10, 16'h0);
        chk("stall2_pc", 32'(PC), 32'h0200);
        chk("stall_err", 32'(ERR), 32'd0);
        chk("stall_empty", 32'(STACK_EMPTY), 32'd0);

        step(0, 1, 0, 0, 0, 0, 8'h00, 16'h0);
        chk("midrst_pc",    32'(PC), 32'(RST_A));
        chk("midrst_empty", 32'(STACK_EMPTY), 32'd1);
        ret();
        chk("midrst_ret_pc",  32'(PC), 32'h0001);
        chk("midrst_ret_err", 32'(ERR), 32'd1);

        seq();
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
